lm70_spi_reader: RTL and testbench
==================================

// Module: lm70_spi_reader
// PURPOSE
//  SPI master front end for the LM70 temperature sensor; sits directly upstream of the
//  celcius display path. Periodically runs a 16-bit read frame on CS/SCK/SIO and checks
//  the fixed status bits. Publishes the signed 11-bit temperature (0.25 C/LSB) with a
//  one-cycle valid strobe for the C/F conversion and 7-seg stages downstream.
// PARAMETERS
//  HALF_DIV       250         CLK cycles per SCK half-period (100 MHz -> 200 kHz SCK); must be >=4
//  SAMPLE_PERIOD  25_000_000  CLK cycles from one frame start to the next (250 ms); must exceed frame length
// PORTS
//  CLK         in   1   system clock, 100 MHz
//  RSTN        in   1   reset, asynchronous assert, active-low
//  EN          in   1   1 = run periodic frames; 0 = idle after the current frame completes
//  SCK         out  1   SPI clock to LM70; idles low
//  CS          out  1   SPI chip select to LM70; active-low, idles high
//  SIO         in   1   SPI data from LM70
//  TEMP_Q      out  11  last good temperature, two's complement, 0.25 C/LSB
//  TEMP_VALID  out  1   one-CLK pulse: TEMP_Q has just been updated
//  FRAME_ERR   out  1   sticky until next good frame: last frame's status bits [4:2] != 3'b111
//  BUSY        out  1   1 while a frame is in progress (CS low through CS_HOLD)
// BEHAVIOUR
//  Reset (RSTN=0, async): SCK=0, CS=1, TEMP_Q=0, TEMP_VALID=0, FRAME_ERR=0, BUSY=0,
//   FSM=IDLE, all counters 0. Reset mid-frame aborts immediately; no partial update.
//  SIO passes a 2-flop synchronizer before use (2 CLK latency; covered by HALF_DIV>=4).
//  Period counter runs whenever EN=1; a frame starts when it reaches SAMPLE_PERIOD-1 and
//   wraps to 0. First frame therefore starts SAMPLE_PERIOD cycles after EN is first seen
//   high (gives the LM70 a full conversion after power-up). EN=0 clears the period counter.
//  FSM: IDLE -> CS_SETUP -> SHIFT -> CS_HOLD -> UPDATE -> IDLE.
//   IDLE:     CS=1, SCK=0; leave on period wrap with EN=1.
//   CS_SETUP: CS=0 for HALF_DIV cycles, SCK=0.
//   SHIFT:    16 SCK periods, each = HALF_DIV low + HALF_DIV high. On the CLK edge that
//             drives SCK 0->1, shift synchronized SIO into a 16-bit register, MSB first.
//             After 16th high phase SCK returns low, go to CS_HOLD.
//   CS_HOLD:  SCK=0, CS=0 for HALF_DIV cycles, then CS=1.
//   UPDATE:   1 cycle. If shift[4:2]==3'b111: TEMP_Q<=shift[15:5], TEMP_VALID=1,
//             FRAME_ERR<=0. Else TEMP_Q unchanged, TEMP_VALID=0, FRAME_ERR<=1. Bits [1:0] ignored.
//  Frame length CS low = HALF_DIV*(2+32) CLK cycles; TEMP_VALID fires 1 cycle after CS rises.
//  EN falling mid-frame: frame completes including UPDATE; no new frame while EN=0.
//  EN toggled within a frame: ignored until IDLE; period count restarts from 0 on re-enable.
//  BUSY=1 in CS_SETUP, SHIFT, CS_HOLD; 0 otherwise.
//  All outputs registered; no combinational path from SIO/EN to outputs.
// STRUCTURE
//  Shared package/include celcius_pkg: LM70_FRAME_BITS=16, LM70_TEMP_BITS=11,
//   LM70_TEMP_MSB=15, LM70_TEMP_LSB=5, LM70_STATUS_OK=3'b111, FSM state encodings.
//  One sub-module: sck_tick_gen (HALF_DIV prescaler, outputs half-period tick, cleared in IDLE).
//  Counter widths via $clog2 of the parameters.
// TESTING (bench uses HALF_DIV=4, SAMPLE_PERIOD=200, LM70 behavioural model drives SIO on SCK fall)
//  1 Reset: hold RSTN=0 -> SCK=0, CS=1, TEMP_Q=0, TEMP_VALID=0, FRAME_ERR=0; assert async mid-cycle.
//  2 +25 C: model word 16'h0C9C -> exactly 16 SCK rises per CS-low window of 136 CLKs,
//    TEMP_Q=11'h064, one TEMP_VALID pulse, FRAME_ERR=0; next frame starts 200 CLKs later.
//  3 -25 C: word 16'hF39C -> TEMP_Q=11'h79C (-100), TEMP_VALID pulse.
//  4 Bad status: good frame 16'h0C9C then 16'h0C80 -> FRAME_ERR=1, TEMP_Q stays 11'h064,
//    no TEMP_VALID; following 16'h0C9C clears FRAME_ERR.
//  5 EN drop: deassert EN at SCK rise #8 -> frame completes and updates, then CS stays high
//    >=1000 CLKs; re-assert -> next frame after 200 CLKs.
//  6 Reset mid-frame: RSTN=0 at SCK rise #10 -> CS=1, SCK=0 immediately; TEMP_Q=0, no VALID.

Source files
------------

// File: rtl/lm70_spi_reader_pkg.sv
// LM70 frame layout constants and reader FSM state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lm70_spi_reader_pkg;

  localparam int LM70_FRAME_BITS = 16;
  localparam int LM70_TEMP_BITS  = 11;
  localparam int LM70_TEMP_MSB   = 15;
  localparam int LM70_TEMP_LSB   = 5;
  localparam int LM70_STAT_MSB   = 4;
  localparam int LM70_STAT_LSB   = 2;
  localparam logic [2:0] LM70_STATUS_OK = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_CS_HOLD  = 3'd3,
    ST_UPDATE   = 3'd4
  } lm70_state_e;

  // A frame is trusted only when its three fixed status bits read back as ones.
  function automatic logic lm70_status_ok(input logic [LM70_FRAME_BITS-1:0] w);
    return w[LM70_STAT_MSB:LM70_STAT_LSB] == LM70_STATUS_OK;
  endfunction

endpackage

// File: rtl/lm70_spi_reader_sck_tick_gen.sv
// SCK half-period prescaler: one-cycle tick every HALF_DIV clocks while not cleared.
// Latency: first tick HALF_DIV cycles after i_clr drops.
// Backpressure: none; free-running while enabled.
module lm70_spi_reader_sck_tick_gen #(
  parameter int HALF_DIV = 250
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF_DIV - 1);

  logic [CW-1:0] r_cnt;

  // Count 0..HALF_DIV-1 and wrap; held at zero while cleared so each frame starts aligned.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/lm70_spi_reader.sv
// LM70 SPI master: periodic 16-bit read frame, status check, publishes 11-bit temperature.
// Latency: TEMP_VALID one cycle after CS rises; frame CS-low time is HALF_DIV*34 clocks.
// Backpressure: none; downstream must accept the one-cycle TEMP_VALID strobe.
module lm70_spi_reader
  import lm70_spi_reader_pkg::*;
#(
  parameter int HALF_DIV      = 250,        // >= 4 so the SIO synchronizer settles within a low phase
  parameter int SAMPLE_PERIOD = 25_000_000  // must exceed the frame length
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_en,
  output logic                      o_sck,
  output logic                      o_cs,
  input  logic                      i_sio,
  output logic [LM70_TEMP_BITS-1:0] o_temp_q,
  output logic                      o_temp_valid,
  output logic                      o_frame_err,
  output logic                      o_busy
);

  localparam int PW = $clog2(SAMPLE_PERIOD);
  localparam logic [PW-1:0] PLAST = PW'(SAMPLE_PERIOD - 1);
  localparam int BW = $clog2(LM70_FRAME_BITS);
  localparam logic [BW-1:0] BLAST = BW'(LM70_FRAME_BITS - 1);

  lm70_state_e                r_state;
  logic [PW-1:0]              r_period_cnt;
  logic [BW-1:0]              r_bit_cnt;
  logic [LM70_FRAME_BITS-1:0] r_shift;
  logic                       r_sio_meta;
  logic                       r_sio_sync;
  logic                       r_sck;
  logic                       r_cs;
  logic                       r_busy;
  logic [LM70_TEMP_BITS-1:0]  r_temp_q;
  logic                       r_temp_valid;
  logic                       r_frame_err;

  logic w_period_wrap;
  logic w_tick;
  logic w_tick_clr;

  assign w_period_wrap = i_en && (r_period_cnt == PLAST);
  assign w_tick_clr    = (r_state == ST_IDLE);

  lm70_spi_reader_sck_tick_gen #(
    .HALF_DIV (HALF_DIV)
  ) u_tick (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_tick_clr),
    .o_tick  (w_tick)
  );

  // Two-flop synchronizer on SIO; the LM70 drives it off our SCK but it is still async to CLK.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sio_meta <= 1'b0;
      r_sio_sync <= 1'b0;
    end else begin
      r_sio_meta <= i_sio;
      r_sio_sync <= r_sio_meta;
    end
  end

  // Frame-rate counter: runs while enabled, restarts from zero whenever EN is low.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_period_cnt <= '0;
    end else if (!i_en || w_period_wrap) begin
      r_period_cnt <= '0;
    end else begin
      r_period_cnt <= r_period_cnt + 1'b1;
    end
  end

  // Frame sequencer; every pin and result output is a register written here.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_sck        <= 1'b0;
      r_cs         <= 1'b1;
      r_busy       <= 1'b0;
      r_temp_q     <= '0;
      r_temp_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_temp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_sck <= 1'b0;
          r_cs  <= 1'b1;
          if (w_period_wrap) begin
            r_state   <= ST_CS_SETUP;
            r_cs      <= 1'b0;
            r_busy    <= 1'b1;
            r_bit_cnt <= '0;
          end
        end
        ST_CS_SETUP: begin
          if (w_tick) begin
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_tick) begin
            if (!r_sck) begin
              // Sample on our own rising edge; the LM70 changed SIO a half period earlier.
              r_sck   <= 1'b1;
              r_shift <= {r_shift[LM70_FRAME_BITS-2:0], r_sio_sync};
            end else begin
              r_sck <= 1'b0;
              if (r_bit_cnt == BLAST) begin
                r_state <= ST_CS_HOLD;
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end
          end
        end
        ST_CS_HOLD: begin
          if (w_tick) begin
            r_cs    <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          // Bad status keeps the previous good reading and flags the frame.
          if (lm70_status_ok(r_shift)) begin
            r_temp_q     <= r_shift[LM70_TEMP_MSB:LM70_TEMP_LSB];
            r_temp_valid <= 1'b1;
            r_frame_err  <= 1'b0;
          end else begin
            r_frame_err  <= 1'b1;
          end
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_sck   <= 1'b0;
          r_cs    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_sck        = r_sck;
  assign o_cs         = r_cs;
  assign o_busy       = r_busy;
  assign o_temp_q     = r_temp_q;
  assign o_temp_valid = r_temp_valid;
  assign o_frame_err  = r_frame_err;

endmodule

// File: tb/tb_lm70_spi_reader.sv
// Bench for lm70_spi_reader: LM70 sensor model on SIO, table vectors, random words, corner sequences.
// Latency: checks CS-low window, SCK count, frame spacing and the post-frame TEMP_VALID strobe.
// Backpressure: n/a.
module tb_lm70_spi_reader;

  localparam int HD     = 4;
  localparam int SP     = 200;
  localparam int CS_LOW = HD * 34;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        en    = 1'b0;
  logic        sio   = 1'b0;
  logic        o_sck;
  logic        o_cs;
  logic [10:0] o_temp_q;
  logic        o_temp_valid;
  logic        o_frame_err;
  logic        o_busy;

  lm70_spi_reader #(
    .HALF_DIV      (HD),
    .SAMPLE_PERIOD (SP)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_en         (en),
    .o_sck        (o_sck),
    .o_cs         (o_cs),
    .i_sio        (sio),
    .o_temp_q     (o_temp_q),
    .o_temp_valid (o_temp_valid),
    .o_frame_err  (o_frame_err),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // LM70 model: presents MSB when CS falls, next bit on every SCK fall while selected.
  logic [15:0] lm70_word = 16'h0000;
  logic [15:0] mdl_sh;
  initial begin
    forever begin
      @(negedge o_cs);
      mdl_sh = lm70_word;
      sio    = mdl_sh[15];
      forever begin
        @(negedge o_sck or posedge o_cs);
        if (o_cs !== 1'b0) break;
        mdl_sh = {mdl_sh[14:0], 1'b0};
        sio    = mdl_sh[15];
      end
    end
  end

  task automatic wait_cs_fall(output int fall_cyc, output bit ok);
    ok = 1'b0;
    fall_cyc = cyc;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (o_cs === 1'b0) begin
        fall_cyc = cyc;
        ok = 1'b1;
        return;
      end
    end
  endtask

  // One full frame: spacing from ref_cyc, CS window, SCK rises, BUSY, then result outputs.
  task automatic run_frame(input string tag, input logic [15:0] word, input logic [10:0] exp_temp,
                           input int exp_vld, input logic exp_err, input int ref_cyc,
                           input int drop_rise, output int fall_cyc);
    int low, rises, busy_bad, vcnt;
    bit ok, prev;
    lm70_word = word;
    wait_cs_fall(fall_cyc, ok);
    check({tag, "_start_seen"}, {31'd0, ok}, 32'd1);
    if (!ok) return;
    check({tag, "_gap"}, fall_cyc - ref_cyc, SP);
    low = 1; rises = 0; prev = o_sck;
    busy_bad = (o_busy !== 1'b1) ? 1 : 0;
    for (int j = 0; j < CS_LOW + 20; j++) begin
      @(negedge clk);
      if (o_cs !== 1'b0) break;
      low++;
      if (o_sck === 1'b1 && !prev) rises++;
      prev = o_sck;
      if (o_busy !== 1'b1) busy_bad++;
      if (drop_rise > 0 && rises == drop_rise) en = 1'b0;
    end
    check({tag, "_cs_low_len"}, low, CS_LOW);
    check({tag, "_sck_rises"}, rises, 16);
    check({tag, "_busy_bad"}, busy_bad, 0);
    vcnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (o_temp_valid === 1'b1) vcnt++;
      @(negedge clk);
    end
    check({tag, "_valid_pulses"}, vcnt, exp_vld);
    check({tag, "_temp_q"}, {21'd0, o_temp_q}, {21'd0, exp_temp});
    check({tag, "_frame_err"}, {31'd0, o_frame_err}, {31'd0, exp_err});
  endtask

  typedef struct {
    logic [15:0] word;
    logic [10:0] exp_temp;
    int          exp_vld;
    logic        exp_err;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1);
  end

  initial begin
    vec_t        tbl[9];
    int          ref_c, fc, quiet_low, rises, vcnt;
    bit          ok, prev;
    logic [15:0] w;
    logic [10:0] mdl_temp;
    int          mdl_vld;
    logic        mdl_err;

    tbl[0] = '{16'h0C9C, 11'h064, 1, 1'b0};   // +25 C
    tbl[1] = '{16'hF39C, 11'h79C, 1, 1'b0};   // -25 C
    tbl[2] = '{16'h0C9C, 11'h064, 1, 1'b0};
    tbl[3] = '{16'h0C80, 11'h064, 0, 1'b1};   // status 000: hold value, flag error
    tbl[4] = '{16'h0C9C, 11'h064, 1, 1'b0};   // good frame clears error
    tbl[5] = '{16'h7FFC, 11'h3FF, 1, 1'b0};   // most positive
    tbl[6] = '{16'h801C, 11'h400, 1, 1'b0};   // most negative
    tbl[7] = '{16'h0CA3, 11'h400, 0, 1'b1};   // status 000 with low bits set
    tbl[8] = '{16'h0C9F, 11'h064, 1, 1'b0};   // bits [1:0] ignored

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_sck", {31'd0, o_sck}, 32'd0);
    check("rst_cs", {31'd0, o_cs}, 32'd1);
    check("rst_temp_q", {21'd0, o_temp_q}, 32'd0);
    check("rst_valid", {31'd0, o_temp_valid}, 32'd0);
    check("rst_frame_err", {31'd0, o_frame_err}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    en = 1'b1;
    ref_c = cyc;

    // Table vectors, back to back
    for (int i = 0; i < 9; i++) begin
      run_frame($sformatf("tbl%0d", i), tbl[i].word, tbl[i].exp_temp, tbl[i].exp_vld,
                tbl[i].exp_err, ref_c, 0, fc);
      ref_c = fc;
    end

    // Random words against the arithmetic model
    mdl_temp = tbl[8].exp_temp;
    for (int r = 0; r < 20; r++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 2) != 0) w[4:2] = 3'b111;
      if (((w / 4) % 8) == 7) begin
        mdl_temp = 11'(w / 32);
        mdl_vld  = 1;
        mdl_err  = 1'b0;
      end else begin
        mdl_vld  = 0;
        mdl_err  = 1'b1;
      end
      run_frame($sformatf("rnd%0d", r), w, mdl_temp, mdl_vld, mdl_err, ref_c, 0, fc);
      ref_c = fc;
    end

    // EN dropped mid-frame: frame still completes and updates, then no more frames
    run_frame("endrop", 16'hF39C, 11'h79C, 1, 1'b0, ref_c, 8, fc);
    quiet_low = 0;
    for (int q = 0; q < 1000; q++) begin
      @(negedge clk);
      if (o_cs !== 1'b1) quiet_low++;
    end
    check("endrop_quiet_cs_low", quiet_low, 0);
    en = 1'b1;
    ref_c = cyc;
    run_frame("reenable", 16'h0C9C, 11'h064, 1, 1'b0, ref_c, 0, fc);

    // Async reset at SCK rise #10 aborts the frame with no update
    lm70_word = 16'h7FFC;
    wait_cs_fall(fc, ok);
    check("midrst_start_seen", {31'd0, ok}, 32'd1);
    rises = 0;
    prev = o_sck;
    for (int j = 0; j < CS_LOW && ok; j++) begin
      @(negedge clk);
      if (o_sck === 1'b1 && !prev) rises++;
      prev = o_sck;
      if (rises == 10) break;
    end
    check("midrst_rise10_seen", rises, 10);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_cs", {31'd0, o_cs}, 32'd1);
    check("midrst_sck", {31'd0, o_sck}, 32'd0);
    check("midrst_busy", {31'd0, o_busy}, 32'd0);
    check("midrst_temp_q", {21'd0, o_temp_q}, 32'd0);
    vcnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (o_temp_valid !== 1'b0) vcnt++;
    end
    check("midrst_valid_pulses", vcnt, 0);
    rst_n = 1'b1;
    ref_c = cyc;
    run_frame("postrst", 16'hF39C, 11'h79C, 1, 1'b0, ref_c, 0, fc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
